can_bit_timing: RTL and testbench

// Bit-timing front end for the CAN receive path: synchronises the raw rx pin, divides clk into time

---
 rtl/can_pkg.sv | 17 +
 rtl/can_tq_prescaler.sv | 39 +++
 rtl/can_bit_timing.sv | 171 +++++++++++++++++
 tb/tb_can_bit_timing.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/can_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | can_pkg : segment encoding and constants shared by the CAN bit-timing |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package can_pkg;

  typedef enum logic [1:0] {
    SEG_SYNC = 2'd0,
    SEG_1    = 2'd1,
    SEG_2    = 2'd2
  } seg_e;

  localparam int CAN_IDLE_BITS = 11;

endpackage
`default_nettype wire

// File: rtl/can_tq_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | can_tq_prescaler : divides clk into time quanta, tq_tick on last clk |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module can_tq_prescaler #(
  parameter int PRESCALE = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tq_tick
);

  localparam int            CW   = $clog2(PRESCALE);
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tq_tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clr || tq_tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/can_bit_timing.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | can_bit_timing : rx synchroniser, tq segment FSM, hard/re-sync, idle |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module can_bit_timing
  import can_pkg::*;
#(
  parameter int PRESCALE = 12,
  parameter int SEG1     = 6,
  parameter int SEG2     = 3,
  parameter int SJW      = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_sync,
  output logic bit_start,
  output logic sample,
  output logic bit_val,
  output logic idle
);

  localparam int             TQW             = $clog2(SEG1 + SJW + 1);
  localparam int             RCW             = $clog2(CAN_IDLE_BITS + 1);
  localparam logic [TQW-1:0] SEG1_T          = TQW'(SEG1);
  localparam logic [TQW-1:0] SJW_T           = TQW'(SJW);
  localparam logic [TQW-1:0] SEG2_LAST       = TQW'(SEG2 - 1);
  localparam logic [TQW-1:0] SEG2_SHORT_LAST = TQW'(SEG2 - SJW - 1);
  localparam logic [TQW-1:0] SEG2_LATE       = TQW'(SEG2 - SJW);
  localparam logic [RCW-1:0] IDLE_CNT        = RCW'(CAN_IDLE_BITS);

  logic           sync1_q, sync2_q, rx_prev_q;
  seg_e           seg_q, seg_d;
  logic [TQW-1:0] tq_q, tq_d, ext_q, ext_d;
  logic           short_q, short_d, synced_q, synced_d;
  logic           bit_start_q, bit_start_d, bit_val_q, bit_val_d;
  logic [RCW-1:0] rec_cnt_q, rec_cnt_d;
  logic           tq_tick, presc_clr, sample_hit;
  logic           fall, can_sync, resync_ok, hard, lengthen, shorten, early, restart;
  logic [TQW-1:0] tq_inc, seg1_last, seg2_last;

  can_tq_prescaler #(.PRESCALE(PRESCALE)) u_presc (
    .clk     (clk),
    .rst     (rst),
    .clr     (presc_clr),
    .tq_tick (tq_tick)
  );

  assign rx_sync   = sync2_q;
  assign bit_start = bit_start_q;
  assign bit_val   = bit_val_q;
  assign idle      = (rec_cnt_q == IDLE_CNT);
  assign sample    = sample_hit & ~rst;

  assign fall      = rx_prev_q & ~sync2_q;
  assign can_sync  = fall & ~synced_q;
  assign hard      = can_sync & idle;
  assign resync_ok = can_sync & ~idle & bit_val_q;
  assign lengthen  = resync_ok && (seg_q == SEG_1);
  // An edge this close to the end of SEG2 belongs to the next bit's SYNC.
  assign early     = resync_ok && (seg_q == SEG_2) && (tq_q >= SEG2_LATE);
  assign shorten   = resync_ok && (seg_q == SEG_2) && (tq_q < SEG2_LATE);
  assign restart   = hard | early;
  assign tq_inc    = tq_q + TQW'(1);

  always_comb begin
    seg_d       = seg_q;
    tq_d        = tq_q;
    ext_d       = ext_q;
    short_d     = short_q;
    synced_d    = synced_q;
    presc_clr   = 1'b0;
    bit_start_d = 1'b0;
    sample_hit  = 1'b0;
    if (lengthen) begin
      ext_d    = (tq_inc < SJW_T) ? tq_inc : SJW_T;
      synced_d = 1'b1;
    end
    if (shorten) begin
      short_d  = 1'b1;
      synced_d = 1'b1;
    end
    seg1_last = SEG1_T + ext_d - TQW'(1);
    seg2_last = short_d ? SEG2_SHORT_LAST : SEG2_LAST;
    if (restart) begin
      seg_d       = SEG_SYNC;
      tq_d        = '0;
      ext_d       = '0;
      short_d     = 1'b0;
      synced_d    = 1'b1;
      presc_clr   = 1'b1;
      bit_start_d = 1'b1;
    end else if (tq_tick) begin
      case (seg_q)
        SEG_SYNC: begin
          seg_d = SEG_1;
          tq_d  = '0;
        end
        SEG_1: begin
          if (tq_q == seg1_last) begin
            seg_d      = SEG_2;
            tq_d       = '0;
            sample_hit = 1'b1;
          end else begin
            tq_d = tq_inc;
          end
        end
        SEG_2: begin
          if (tq_q == seg2_last) begin
            seg_d       = SEG_SYNC;
            tq_d        = '0;
            ext_d       = '0;
            short_d     = 1'b0;
            synced_d    = 1'b0;
            bit_start_d = 1'b1;
          end else begin
            tq_d = tq_inc;
          end
        end
        default: begin
          seg_d = SEG_SYNC;
          tq_d  = '0;
        end
      endcase
    end
  end

  always_comb begin
    bit_val_d = bit_val_q;
    rec_cnt_d = rec_cnt_q;
    if (sample) begin
      bit_val_d = sync2_q;
      if (!sync2_q) begin
        rec_cnt_d = '0;
      end else if (!idle) begin
        rec_cnt_d = rec_cnt_q + RCW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      seg_q       <= SEG_SYNC;
      tq_q        <= '0;
      ext_q       <= '0;
      short_q     <= 1'b0;
      synced_q    <= 1'b0;
      bit_start_q <= 1'b0;
      bit_val_q   <= 1'b1;
      rec_cnt_q   <= '0;
    end else begin
      sync1_q     <= rx;
      sync2_q     <= sync1_q;
      rx_prev_q   <= sync2_q;
      seg_q       <= seg_d;
      tq_q        <= tq_d;
      ext_q       <= ext_d;
      short_q     <= short_d;
      synced_q    <= synced_d;
      bit_start_q <= bit_start_d;
      bit_val_q   <= bit_val_d;
      rec_cnt_q   <= rec_cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_can_bit_timing.sv
`default_nettype none
// Bench for can_bit_timing: directed scenarios then random rx activity, every cycle
// compared with a model that tracks position within the bit as a plain clk count.
module tb_can_bit_timing;

  localparam int PRESCALE  = 12;
  localparam int SEG1      = 6;
  localparam int SEG2      = 3;
  localparam int SJW       = 1;
  localparam int IDLE_BITS = 11;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;
  logic rx_sync, bit_start, sample, bit_val, idle;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;

  logic [2:0] m_h = 3'b111;
  int  m_cyc = 0, m_t0 = 0, m_s1len = SEG1, m_s2len = SEG2, m_rec = 0;
  bit  m_synced = 1'b0, m_bs = 1'b0, m_bv = 1'b1;
  int  m_last_edge = -100000, last_bs = -100000, last_smp = -100000;
  int  e, t0;

  can_bit_timing #(
    .PRESCALE (PRESCALE),
    .SEG1     (SEG1),
    .SEG2     (SEG2),
    .SJW      (SJW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rx        (rx),
    .rx_sync   (rx_sync),
    .bit_start (bit_start),
    .sample    (sample),
    .bit_val   (bit_val),
    .idle      (idle)
  );

  always #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk_bit(input string tag, input logic obs, input logic exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %b expected %b", tag, m_cyc, obs, exp_v);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp_v);
    checks++;
    assert (obs == exp_v) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // One clk: drive inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input logic rx_v, input logic rst_v);
    int pos, tqn, k;
    bit fall, restart, smp;
    @(posedge clk);
    #1;
    rx  = rx_v;
    rst = rst_v;
    @(negedge clk);
    pos     = m_cyc - m_t0;
    tqn     = pos / PRESCALE;
    fall    = (m_h[2] == 1'b1) && (m_h[1] == 1'b0);
    restart = 1'b0;
    if (fall) m_last_edge = m_cyc;
    if (fall && !m_synced && !rst_v) begin
      if (m_rec >= IDLE_BITS) begin
        restart = 1'b1;
      end else if (m_bv) begin
        if (tqn == 0) begin
          restart = 1'b0;
        end else if (tqn <= m_s1len) begin
          k = tqn - 1;
          m_s1len  = SEG1 + (((k + 1) < SJW) ? (k + 1) : SJW);
          m_synced = 1'b1;
        end else begin
          k = tqn - 1 - m_s1len;
          if ((SEG2 - k) <= SJW) begin
            restart = 1'b1;
          end else begin
            m_s2len  = SEG2 - SJW;
            m_synced = 1'b1;
          end
        end
      end
    end
    smp = !rst_v && !restart && (pos == (1 + m_s1len) * PRESCALE - 1);
    if (chk_on) begin
      chk_bit("rx_sync", rx_sync, m_h[1]);
      chk_bit("bit_start", bit_start, m_bs);
      chk_bit("sample", sample, smp);
      chk_bit("bit_val", bit_val, m_bv);
      chk_bit("idle", idle, logic'(m_rec >= IDLE_BITS));
    end
    if (bit_start === 1'b1) last_bs = m_cyc;
    if (sample === 1'b1) last_smp = m_cyc;
    if (rst_v) begin
      m_h = 3'b111; m_t0 = m_cyc + 1; m_s1len = SEG1; m_s2len = SEG2;
      m_synced = 1'b0; m_bs = 1'b0; m_rec = 0; m_bv = 1'b1;
    end else begin
      m_bs = 1'b0;
      if (smp) begin
        m_bv  = m_h[1];
        m_rec = m_h[1] ? ((m_rec < IDLE_BITS) ? m_rec + 1 : IDLE_BITS) : 0;
      end
      if (restart || (pos == (1 + m_s1len + m_s2len) * PRESCALE - 1)) begin
        m_t0 = m_cyc + 1; m_s1len = SEG1; m_s2len = SEG2;
        m_synced = restart; m_bs = 1'b1;
      end
      m_h = {m_h[1], m_h[0], rx_v};
    end
    m_cyc++;
  endtask

  task automatic run(input logic v, input int n);
    for (int i = 0; i < n; i++) step(v, 1'b0);
  endtask

  task automatic step_to_pos(input int target);
    int n;
    n = 0;
    while (((m_cyc - m_t0) != target) && (n < 2000)) begin
      step(1'b1, 1'b0);
      n++;
    end
    chk_bit("align_in_budget", logic'(n < 2000), 1'b1);
  endtask

  // Drive rx low so that rx_sync falls exactly at bit position target.
  task automatic drive_edge_at(input int target);
    step_to_pos(target - 2);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  initial begin
    step(1'b1, 1'b1);
    chk_on = 1'b1;
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);

    run(1'b1, 1400);
    chk_bit("idle_after_11_bits", idle, 1'b1);

    run(1'b0, 3);
    e = m_last_edge;
    run(1'b0, 1);
    chk_int("hard_sync_bit_start_lat", last_bs - e, 1);
    run(1'b0, 90);
    chk_int("hard_sync_sample_lat", last_smp - e, 84);
    chk_bit("hard_sync_bit_val", bit_val, 1'b0);
    run(1'b1, 250);

    drive_edge_at(27);
    t0 = m_last_edge - 27;
    run(1'b0, 85);
    chk_int("late_edge_sample_pos", last_smp - t0, 95);
    run(1'b0, 40);
    chk_int("late_edge_bit_len", last_bs - t0, 132);
    run(1'b1, 250);

    drive_edge_at(113);
    e = m_last_edge;
    run(1'b0, 1);
    chk_int("early_edge_bit_start_lat", last_bs - e, 1);
    run(1'b0, 100);
    run(1'b1, 250);

    drive_edge_at(40);
    t0 = m_last_edge - 40;
    run(1'b0, 10);
    drive_edge_at(100);
    run(1'b0, 40);
    chk_int("two_edges_bit_len", last_bs - t0, 132);
    run(1'b1, 250);

    run(1'b1, 1400);
    chk_bit("idle_before_reset", idle, 1'b1);
    step_to_pos(83);
    step(1'b1, 1'b1);
    chk_bit("reset_cycle_no_sample", sample, 1'b0);
    step(1'b1, 1'b0);
    chk_bit("post_reset_idle", idle, 1'b0);
    chk_bit("post_reset_bit_start", bit_start, 1'b0);
    chk_bit("post_reset_bit_val", bit_val, 1'b1);

    for (int i = 0; i < 25; i++) begin
      int a, b;
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1300, 1500))
                                      : int'($urandom_range(1, 250));
      b = int'($urandom_range(1, 250));
      run(1'b1, a);
      if ($urandom_range(0, 1) == 1) begin
        run(1'b0, int'($urandom_range(1, 8)));
        run(1'b1, int'($urandom_range(1, 40)));
      end
      run(1'b0, b);
    end
    run(1'b1, 300);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
